nr_div_seq_ctrl: RTL

- Sequential non-restoring unsigned divider controller.
- Sits directly upstream of the controlled add/subtract (CAS) row datapath: each cycle it drives one CAS-row operation and captures that row's sign/quotient bit and partial remainder.
- Iterates the rows in time instead of unrolling an N-row array.
- Exposes a valid/ready operand port and a valid/ready result port.

---
 rtl/nr_div_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nr_div_seq_ctrl.sv
// Sequential non-restoring unsigned divider: one CAS row per cycle, N rows, then one remainder fix-up cycle.
// Optional zero-divisor shortcut enabled by defining NR_DIV_ZERO_DETECT_EN.
module nr_div_seq_ctrl #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [N:0]    r_q, r_d;      // partial remainder, two's complement
  logic [N-1:0]  a_q, a_d;      // dividend in, quotient out
  logic [N:0]    d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_q, p_d;      // 1: subtract on next row
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;

  logic [N:0] r_shift;
  logic [N:0] r_row;
  logic [N:0] r_fix;

  // CAS row: shift in the next dividend bit, then add or subtract the divisor.
  assign r_shift = {r_q[N-1:0], a_q[N-1]};
  assign r_row   = p_q ? (r_shift - d_q) : (r_shift + d_q);
  assign r_fix   = r_q[N] ? (r_q + d_q) : r_q;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

`ifdef NR_DIV_ZERO_DETECT_EN
  logic dz_q, dz_d;
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef NR_DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = dividend;
          d_d     = {1'b0, divisor};
          r_d     = '0;
          cnt_d   = '0;
          p_d     = 1'b1;
`ifdef NR_DIV_ZERO_DETECT_EN
          dz_d    = 1'b0;
`endif
          state_d = CALC;
        end
      end

      CALC: begin
`ifdef NR_DIV_ZERO_DETECT_EN
        // A_q still holds the untouched dividend on the first CALC cycle.
        if (d_q == '0) begin
          quo_d   = '1;
          rem_d   = a_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end else
`endif
        begin
          r_d   = r_row;
          a_d   = {a_q[N-2:0], ~r_row[N]};
          p_d   = ~r_row[N];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ROW) state_d = FIX;
        end
      end

      FIX: begin
        r_d     = r_fix;
        quo_d   = a_q;
        rem_d   = r_fix[N-1:0];
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      a_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      p_q     <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

`ifdef NR_DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dz_q <= 1'b0;
    else     dz_q <= dz_d;
  end
`endif

endmodule
